// File: rtl/axi_write_rr_sched_pkg.sv
// Shared types and constants for the AXI write-path round-robin scheduler.
// Contents:
//   sched_state_t : write-path sequencing states (IDLE, ADDR, DATA, RESP)
//   AXI_LEN_W     : AXI awlen width
package axi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  localparam int AXI_LEN_W = 8;

endpackage

// File: rtl/axi_write_rr_sched_if.sv
// Interface bundling the scheduler's request/handshake inputs and its
// grant/phase outputs.
//   slave modport  : the scheduler side (requests and handshakes in, grant out)
//   master modport : the interconnect/environment side (the reverse)
// Optional macro AXI_SCHED_LAST_CHECK_EN adds the sticky proto_err output.
//
// Handshake semantics: a transfer on any channel happens in a cycle where
// both valid and ready are high at the rising clock edge; valid, once raised,
// is expected to stay high until that edge.
interface axi_write_rr_sched_if
  import axi_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = AXI_LEN_W
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_awvalid;
  logic [NUM_REQ*LEN_W-1:0] req_awlen;
  logic                     m_awready;
  logic                     m_wvalid;
  logic                     m_wready;
  logic                     m_wlast;
  logic                     m_bvalid;
  logic                     m_bready;

  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic [NUM_REQ-1:0]       grant_onehot;
  logic                     aw_phase;
  logic                     w_phase;
  logic                     b_phase;
  logic [LEN_W-1:0]         beats_left;
`ifdef AXI_SCHED_LAST_CHECK_EN
  logic                     proto_err;
`endif

  modport slave (
    input  req_awvalid, req_awlen, m_awready, m_wvalid, m_wready, m_wlast,
           m_bvalid, m_bready,
`ifdef AXI_SCHED_LAST_CHECK_EN
    output proto_err,
`endif
    output grant_valid, grant_idx, grant_onehot, aw_phase, w_phase, b_phase,
           beats_left
  );

  modport master (
    output req_awvalid, req_awlen, m_awready, m_wvalid, m_wready, m_wlast,
           m_bvalid, m_bready,
`ifdef AXI_SCHED_LAST_CHECK_EN
    input  proto_err,
`endif
    input  grant_valid, grant_idx, grant_onehot, aw_phase, w_phase, b_phase,
           beats_left
  );

endinterface

// File: rtl/axi_write_rr_sched_pick.sv
// rr_priority_pick: combinational rotating-priority picker.
// Scans req upward starting at ptr, wrapping at NUM_REQ, and reports the
// first set bit. Shared by the write- and read-side schedulers.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    highest-priority position
//   found  out 1        any request set
//   idx    out IDX_W    winning index (0 when nothing found)
//   onehot out NUM_REQ  one-hot winner (0 when nothing found)
module rr_priority_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  int cand;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot[i] = found && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/axi_write_rr_sched.sv
// axi_write_rr_sched: round-robin owner of the shared AXI write path.
// Picks one requester from its awvalid, then holds that grant through the AW
// handshake, every W beat (counted from awlen) and the B response. The phase
// outputs gate the interconnect's AW/W/B muxes; no data passes through here.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   bus (slave)       request/handshake inputs, grant/phase/beats_left outputs
//   dbg_state         current sequencing state
//   dbg_rr_ptr        current round-robin priority pointer
// Optional macro AXI_SCHED_LAST_CHECK_EN: adds sticky bus.proto_err, set on a
// W handshake whose wlast disagrees with the beat count, or on bvalid seen
// outside the response phase. Without it m_wlast is unused.
module axi_write_rr_sched
  import axi_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = AXI_LEN_W,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  axi_write_rr_sched_if.slave bus,
  output sched_state_t     dbg_state,
  output logic [IDX_W-1:0] dbg_rr_ptr
);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;
  logic [LEN_W-1:0]   beats_q, beats_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [LEN_W-1:0]   winner_len;
  logic [IDX_W-1:0]   next_ptr;
  logic               aw_hs, w_hs, b_hs;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req_awvalid),
    .ptr    (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign winner_len = bus.req_awlen[int'(pick_idx)*LEN_W +: LEN_W];

  // Handshakes only count in the phase that owns the channel.
  assign aw_hs = (state_q == ADDR) && |(bus.req_awvalid & onehot_q) && bus.m_awready;
  assign w_hs  = (state_q == DATA) && bus.m_wvalid && bus.m_wready;
  assign b_hs  = (state_q == RESP) && bus.m_bvalid && bus.m_bready;

  // Priority moves to the requester just after the one that finished.
  assign next_ptr = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      onehot_q    <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      onehot_q    <= onehot_d;
      beats_q     <= beats_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    onehot_d    = onehot_q;
    beats_d     = beats_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = ADDR;
          grant_idx_d = pick_idx;
          onehot_d    = pick_onehot;
          beats_d     = winner_len;
        end
      end
      ADDR: begin
        // A requester that drops awvalid here simply stalls the path.
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        // The beat count alone ends the burst; wlast is not consulted.
        if (w_hs) begin
          if (beats_q == '0) state_d = RESP;
          else               beats_d = beats_q - 1'b1;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d     = IDLE;
          rr_ptr_d    = next_ptr;
          grant_idx_d = '0;
          onehot_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant_valid  = (state_q != IDLE);
  assign bus.grant_idx    = grant_idx_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.aw_phase     = (state_q == ADDR);
  assign bus.w_phase      = (state_q == DATA);
  assign bus.b_phase      = (state_q == RESP);
  assign bus.beats_left   = beats_q;
  assign dbg_state        = state_q;
  assign dbg_rr_ptr       = rr_ptr_q;

`ifdef AXI_SCHED_LAST_CHECK_EN
  logic perr_q;
  logic last_mismatch;
  logic stray_b;

  assign last_mismatch = w_hs && (bus.m_wlast != (beats_q == '0));
  assign stray_b       = bus.m_bvalid && (state_q != RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         perr_q <= 1'b0;
    else if (last_mismatch || stray_b) perr_q <= 1'b1;
  end

  assign bus.proto_err = perr_q;
`else
  logic unused_wlast;
  assign unused_wlast = bus.m_wlast;
`endif

endmodule

// File: tb/tb_axi_write_rr_sched.sv
// Bench for axi_write_rr_sched (NUM_REQ=2, LEN_W=8).
// A transaction-level model (owner, AW done flag, beats still owed, next
// priority) predicts every output each cycle; directed sequences add literal
// expectations on grant order, beat counts, idle gaps and reset behaviour.
module tb_axi_write_rr_sched;
  import axi_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int LEN_W   = 8;
  localparam int IDX_W   = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axi_write_rr_sched_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();
  sched_state_t     dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;

  axi_write_rr_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- behavioural model ----------------
  int owner     = -1;  // requester holding the path, -1 if none
  bit aw_done   = 1'b0;
  int beats_rem = 0;   // W beats still owed
  int rr_next   = 0;
  int cur_len   = 0;
  bit model_perr = 1'b0;

  function automatic int pick(input logic [NUM_REQ-1:0] req, input int from);
    for (int i = 0; i < NUM_REQ; i++)
      if (req[(from + i) % NUM_REQ]) return (from + i) % NUM_REQ;
    return -1;
  endfunction

  function automatic int len_of(input logic [NUM_REQ*LEN_W-1:0] v, input int i);
    logic [LEN_W-1:0] l;
    l = v[i*LEN_W +: LEN_W];
    return int'(l);
  endfunction

  function automatic bit in_resp();
    return (owner >= 0) && aw_done && (beats_rem == 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= -1;
      aw_done    <= 1'b0;
      beats_rem  <= 0;
      rr_next    <= 0;
      cur_len    <= 0;
      model_perr <= 1'b0;
    end else begin
      if (bus.m_bvalid && !in_resp()) model_perr <= 1'b1;
      if (owner < 0) begin
        if (|bus.req_awvalid) begin
          owner     <= pick(bus.req_awvalid, rr_next);
          aw_done   <= 1'b0;
          cur_len   <= len_of(bus.req_awlen, pick(bus.req_awvalid, rr_next));
          beats_rem <= len_of(bus.req_awlen, pick(bus.req_awvalid, rr_next)) + 1;
        end
      end else if (!aw_done) begin
        if (bus.req_awvalid[owner] && bus.m_awready) aw_done <= 1'b1;
      end else if (beats_rem > 0) begin
        if (bus.m_wvalid && bus.m_wready) begin
          beats_rem <= beats_rem - 1;
          if (bus.m_wlast != (beats_rem == 1)) model_perr <= 1'b1;
        end
      end else if (bus.m_bvalid && bus.m_bready) begin
        owner   <= -1;
        rr_next <= (owner + 1) % NUM_REQ;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("grant_valid",  bus.grant_valid,  owner >= 0);
    chk("grant_idx",    bus.grant_idx,    (owner >= 0) ? owner : 0);
    chk("grant_onehot", bus.grant_onehot, (owner >= 0) ? (1 << owner) : 0);
    chk("aw_phase",     bus.aw_phase,     (owner >= 0) && !aw_done);
    chk("w_phase",      bus.w_phase,      (owner >= 0) && aw_done && beats_rem > 0);
    chk("b_phase",      bus.b_phase,      in_resp());
    chk("beats_left",   bus.beats_left,   (beats_rem > 0) ? beats_rem - 1 : 0);
    chk("rr_ptr",       dbg_rr_ptr,       rr_next);
`ifdef AXI_SCHED_LAST_CHECK_EN
    chk("proto_err",    bus.proto_err,    model_perr);
`endif
  endtask

  // ---------------- observation of DUT traffic ----------------
  int dut_beats = 0;
  int dut_grants[$];
  int idle_gaps[$];
  int idle_run  = 0;
  bit prev_gv   = 1'b0;
  bit saw_b     = 1'b0;

  task automatic observe();
    if (bus.w_phase && bus.m_wvalid && bus.m_wready) dut_beats++;
    if (bus.b_phase) saw_b = 1'b1;
    if (bus.grant_valid && !prev_gv) begin
      dut_grants.push_back(int'(bus.grant_idx));
      idle_gaps.push_back(idle_run);
      idle_run = 0;
    end
    if (!bus.grant_valid) idle_run++;
    prev_gv = bus.grant_valid;
  endtask

  // ---------------- driver ----------------
  bit wtoggle      = 1'b0;
  bit auto_drop    = 1'b1;
  bit inject_early = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.m_awready = 1'b1;
    bus.m_wvalid  = 1'b1;
    bus.m_wready  = wtoggle ? ~bus.m_wready : 1'b1;
    bus.m_wlast   = (beats_rem == 1) ||
                    (inject_early && owner >= 0 && aw_done && (cur_len + 1 - beats_rem) == 1);
    bus.m_bvalid  = in_resp();
    bus.m_bready  = 1'b1;
    if (auto_drop && owner >= 0 && aw_done) bus.req_awvalid[owner] = 1'b0;
    @(negedge clk);
    compare_all();
    observe();
  endtask

  task automatic request(input int idx, input int len);
    bus.req_awlen[idx*LEN_W +: LEN_W] = LEN_W'(len);
    bus.req_awvalid[idx] = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    tick();
    while ((bus.grant_valid || owner >= 0) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic reset_pulse();
    bus.req_awvalid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    int base;
    int n;
    int bad;
    bus.req_awvalid = '0;
    bus.req_awlen   = '0;
    bus.m_awready   = 1'b0;
    bus.m_wvalid    = 1'b0;
    bus.m_wready    = 1'b0;
    bus.m_wlast     = 1'b0;
    bus.m_bvalid    = 1'b0;
    bus.m_bready    = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_grant_valid", bus.grant_valid, 0);
    chk("rst_beats_left",  bus.beats_left,  0);
    chk("rst_rr_ptr",      dbg_rr_ptr,      0);

    // 1: single burst of 4 beats from requester 0
    base  = dut_beats;
    saw_b = 1'b0;
    request(0, 3);
    tick();
    chk("t1_latency_gv",  bus.grant_valid, 1);
    chk("t1_latency_idx", bus.grant_idx,   0);
    chk("t1_beats_left",  bus.beats_left,  3);
    wait_idle("t1", 40);
    chk("t1_beat_count", dut_beats - base, 4);
    chk("t1_saw_b",      saw_b,            1);
    chk("t1_rr_ptr",     dbg_rr_ptr,       1);

    // 2: both requesters hold awvalid, awlen=0 -> strict alternation
    reset_pulse();
    base = dut_grants.size();
    auto_drop = 1'b0;
    request(0, 0);
    request(1, 0);
    n = 0;
    while (!(dut_grants.size() >= base + 4 && !bus.aw_phase) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) chk("t2_timeout", 1, 0);
    bus.req_awvalid = '0;
    auto_drop = 1'b1;
    wait_idle("t2", 40);
    if (dut_grants.size() >= base + 4) begin
      chk("t2_grant0", dut_grants[base],     0);
      chk("t2_grant1", dut_grants[base + 1], 1);
      chk("t2_grant2", dut_grants[base + 2], 0);
      chk("t2_grant3", dut_grants[base + 3], 1);
      chk("t2_gap1",   idle_gaps[base + 1],  1);
      chk("t2_gap2",   idle_gaps[base + 2],  1);
      chk("t2_gap3",   idle_gaps[base + 3],  1);
    end else begin
      chk("t2_grant_count", dut_grants.size() - base, 4);
    end

    // 3: 256-beat burst with wready toggling every cycle
    base    = dut_beats;
    wtoggle = 1'b1;
    request(0, 255);
    wait_idle("t3", 1000);
    wtoggle = 1'b0;
    chk("t3_beat_count", dut_beats - base, 256);
    chk("t3_beats_left", bus.beats_left,   0);

    // 4: requester 1 arrives while requester 0 is mid-burst
    base = dut_grants.size();
    request(0, 3);
    n = 0;
    while (!bus.w_phase && n < 20) begin
      tick();
      n++;
    end
    request(1, 1);
    bad = 0;
    n = 0;
    while (dut_grants.size() < base + 2 && n < 60) begin
      tick();
      if (dut_grants.size() == base + 1 && bus.grant_valid && bus.grant_idx != 0) bad++;
      n++;
    end
    chk("t4_hold_owner", bad, 0);
    if (dut_grants.size() >= base + 2) begin
      chk("t4_first",  dut_grants[base],     0);
      chk("t4_second", dut_grants[base + 1], 1);
    end else begin
      chk("t4_grant_count", dut_grants.size() - base, 2);
    end
    wait_idle("t4", 40);

    // 5: reset in the middle of a burst with a non-zero pointer
    request(0, 0);
    wait_idle("t5a", 20);
    chk("t5_ptr_before", dbg_rr_ptr, 1);
    request(1, 7);
    n = 0;
    while (!(bus.w_phase && bus.beats_left == 5) && n < 30) begin
      tick();
      n++;
    end
    chk("t5_reached_5", bus.beats_left, 5);
    reset = 1'b1;
    bus.req_awvalid = '0;
    #1;
    chk("t5_gv",     bus.grant_valid,  0);
    chk("t5_idx",    bus.grant_idx,    0);
    chk("t5_onehot", bus.grant_onehot, 0);
    chk("t5_phases", {bus.aw_phase, bus.w_phase, bus.b_phase}, 0);
    chk("t5_beats",  bus.beats_left,   0);
    chk("t5_ptr",    dbg_rr_ptr,       0);
    tick();
    reset = 1'b0;
    tick();
    request(0, 0);
    request(1, 0);
    tick();
    chk("t5_regrant", bus.grant_idx, 0);
    bus.req_awvalid[1] = 1'b0;
    wait_idle("t5b", 20);

`ifdef AXI_SCHED_LAST_CHECK_EN
    // 6: early wlast on beat 2 of a 4-beat burst
    reset_pulse();
    chk("t6_perr_clear", bus.proto_err, 0);
    base = dut_beats;
    inject_early = 1'b1;
    request(0, 3);
    wait_idle("t6", 40);
    inject_early = 1'b0;
    chk("t6_perr_set",    bus.proto_err,    1);
    chk("t6_beat_count",  dut_beats - base, 4);
    tick();
    tick();
    chk("t6_perr_sticky", bus.proto_err,    1);
`endif

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
